// File: rtl/gte_pkg.sv
// Shared GTE write-back definitions: result-target select, CPU register map,
// FLAG layout and the packed register-state struct seen by the read muxes.
package gte_pkg;

  // Result targets the compute path can write.
  typedef enum logic [3:0] {
    WB_MAC0     = 4'd0,
    WB_MAC1     = 4'd1,
    WB_MAC2     = 4'd2,
    WB_MAC3     = 4'd3,
    WB_IR0      = 4'd4,
    WB_IR1      = 4'd5,
    WB_IR2      = 4'd6,
    WB_IR3      = 4'd7,
    WB_OTZ      = 4'd8,
    WB_SXY_PUSH = 4'd9,
    WB_SZ_PUSH  = 4'd10,
    WB_RGB_PUSH = 4'd11
  } gteWbSel_t;

  // CPU register map. Each banked group starts on a 4-aligned address, so
  // cpuAddr[1:0] is the element index inside the group.
  localparam logic [5:0] CPU_OTZ  = 6'd7;
  localparam logic [5:0] CPU_IR0  = 6'd8;
  localparam logic [5:0] CPU_IR3  = 6'd11;
  localparam logic [5:0] CPU_SXY0 = 6'd12;
  localparam logic [5:0] CPU_SXY2 = 6'd14;
  localparam logic [5:0] CPU_SXYP = 6'd15;
  localparam logic [5:0] CPU_SZ0  = 6'd16;
  localparam logic [5:0] CPU_SZ3  = 6'd19;
  localparam logic [5:0] CPU_RGB0 = 6'd20;
  localparam logic [5:0] CPU_RGB2 = 6'd22;
  localparam logic [5:0] CPU_MAC0 = 6'd24;
  localparam logic [5:0] CPU_MAC3 = 6'd27;
  localparam logic [5:0] CPU_LZCS = 6'd30;
  localparam logic [5:0] CPU_LZCR = 6'd31;
  localparam logic [5:0] CPU_FLAG = 6'd63;

  // FLAG layout: stored bits [30:12]; bit 31 is a summary of two ranges.
  localparam logic [31:0] GTE_FLAG_WMASK = 32'h7FFF_F000;
  localparam int FLAG_SUM_HI_MSB = 30;
  localparam int FLAG_SUM_HI_LSB = 23;
  localparam int FLAG_SUM_LO_MSB = 18;
  localparam int FLAG_SUM_LO_LSB = 13;

  // Full result-register state, MSB field first (534 bits).
  typedef struct packed {
    logic [2:0][31:0] sxy;
    logic [3:0][15:0] sz;
    logic [2:0][31:0] rgb;
    logic [3:0][31:0] mac;
    logic [3:0][15:0] ir;
    logic [15:0]      otz;
    logic [31:0]      flag;
    logic [31:0]      lzcs;
    logic [5:0]       lzcr;
  } gteWbRegs_t;

  // FLAG[31]: error summary over the saturation bits that abort results.
  function automatic logic flagSummary(input logic [31:0] flag);
    return (|flag[FLAG_SUM_HI_MSB:FLAG_SUM_HI_LSB]) |
           (|flag[FLAG_SUM_LO_MSB:FLAG_SUM_LO_LSB]);
  endfunction

endpackage

// File: rtl/gte_reg_writeback_if.sv
// Write-command handshake from the GTE compute path to the write-back block.
interface gte_reg_writeback_if;
  import gte_pkg::*;

  logic        wbValid;
  logic        wbReady;
  gteWbSel_t   wbSel;
  logic [31:0] wbData;
  logic [31:0] wbFlags;

  modport master (output wbValid, wbSel, wbData, wbFlags, input wbReady);
  modport slave  (input wbValid, wbSel, wbData, wbFlags, output wbReady);
endinterface

// File: rtl/gte_lzc.sv
// Leading-sign-bit counter: number of leading bits equal to bit 31 (1..32).
module gte_lzc (
  input  logic [31:0] i_data,
  output logic [5:0]  o_count
);

  logic [31:0] diff;
  logic        found;

  // Scan from the MSB for the first bit that differs from the sign bit.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    diff    = i_data ^ {32{i_data[31]}};
    o_count = 6'd32;
    found   = 1'b0;
    for (int i = 30; i >= 0; i--) begin
      if (!found && diff[i]) begin
        o_count = 6'(31 - i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gte_reg_writeback.sv
// GTE write-back: owns MAC/IR/OTZ, the SXY/SZ/RGB FIFOs, FLAG and LZCS/LZCR.
// Accepts compute-path write commands and CPU MTC2/CTC2 writes (CPU wins).
// Optional: `GTE_WB_LZC_EN makes a CPU write to LZCS also load LZCR.
module gte_reg_writeback
  import gte_pkg::*;
#(
  parameter logic [31:0] FLAG_WMASK = GTE_FLAG_WMASK
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_instrStart,
  gte_reg_writeback_if.slave   wb,
  input  logic                 i_cpuWr,
  input  logic [5:0]           i_cpuAddr,
  input  logic [31:0]          i_cpuData,
  output gteWbRegs_t           o_regs
);

  gteWbRegs_t  st;
  logic        wbAccept;
  logic [31:0] flagBase;
  logic        sxyPush;
  logic [31:0] sxyPushData;

`ifdef GTE_WB_LZC_EN
  logic [5:0] lzcCount;

  gte_lzc u_lzc (
    .i_data  (i_cpuData),
    .o_count (lzcCount)
  );
`endif

  // A stalled command keeps valid high and is taken once the CPU lets go.
  assign wb.wbReady = ~i_rst & ~i_cpuWr;
  assign wbAccept   = wb.wbValid & wb.wbReady;

  // Instruction start clears FLAG before this cycle's flags are ORed in;
  // the SXY FIFO is pushed by either source (never both: CPU blocks accept).
  always_comb begin
    flagBase    = i_instrStart ? '0 : st.flag;
    sxyPush     = (wbAccept && wb.wbSel == WB_SXY_PUSH) ||
                  (i_cpuWr && i_cpuAddr == CPU_SXYP);
    sxyPushData = i_cpuWr ? i_cpuData : wb.wbData;
  end

  // Register state update from write commands and CPU writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the FIFO entries are reset like every other register, since the
      // read muxes must see all-zero state straight out of reset.
      st <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; a later assignment to the
      // same field in this block overrides an earlier one.
      if (i_instrStart) st.flag <= '0;

      if (sxyPush) begin
        st.sxy[0] <= st.sxy[1];
        st.sxy[1] <= st.sxy[2];
        st.sxy[2] <= sxyPushData;
      end

      if (wbAccept) begin
        st.flag <= flagBase | (wb.wbFlags & FLAG_WMASK);
        case (wb.wbSel)
          WB_MAC0:     st.mac[0] <= wb.wbData;
          WB_MAC1:     st.mac[1] <= wb.wbData;
          WB_MAC2:     st.mac[2] <= wb.wbData;
          WB_MAC3:     st.mac[3] <= wb.wbData;
          WB_IR0:      st.ir[0]  <= wb.wbData[15:0];
          WB_IR1:      st.ir[1]  <= wb.wbData[15:0];
          WB_IR2:      st.ir[2]  <= wb.wbData[15:0];
          WB_IR3:      st.ir[3]  <= wb.wbData[15:0];
          WB_OTZ:      st.otz    <= wb.wbData[15:0];
          WB_SZ_PUSH: begin
            st.sz[0] <= st.sz[1];
            st.sz[1] <= st.sz[2];
            st.sz[2] <= st.sz[3];
            st.sz[3] <= wb.wbData[15:0];
          end
          WB_RGB_PUSH: begin
            st.rgb[0] <= st.rgb[1];
            st.rgb[1] <= st.rgb[2];
            st.rgb[2] <= wb.wbData;
          end
          default: ;
        endcase
      end

      if (i_cpuWr) begin
        case (i_cpuAddr) inside
          CPU_OTZ:              st.otz <= i_cpuData[15:0];
          [CPU_IR0:CPU_IR3]:    st.ir[i_cpuAddr[1:0]]  <= i_cpuData[15:0];
          [CPU_SXY0:CPU_SXY2]:  st.sxy[i_cpuAddr[1:0]] <= i_cpuData;
          [CPU_SZ0:CPU_SZ3]:    st.sz[i_cpuAddr[1:0]]  <= i_cpuData[15:0];
          [CPU_RGB0:CPU_RGB2]:  st.rgb[i_cpuAddr[1:0]] <= i_cpuData;
          [CPU_MAC0:CPU_MAC3]:  st.mac[i_cpuAddr[1:0]] <= i_cpuData;
          CPU_LZCS: begin
            st.lzcs <= i_cpuData;
`ifdef GTE_WB_LZC_EN
            st.lzcr <= lzcCount;
`endif
          end
          CPU_FLAG:             st.flag <= i_cpuData & FLAG_WMASK;
          // SXYP is handled by the shared push above; LZCR is read-only and
          // the remaining addresses belong to the input register file.
          default: ;
        endcase
      end
    end
  end

  // Present the state with the derived FLAG summary bit.
  always_comb begin
    o_regs         = st;
    o_regs.flag[31] = flagSummary(st.flag);
  end

endmodule

// File: tb/tb_gte_reg_writeback.sv
// Directed, table-driven bench for gte_reg_writeback plus hand-written
// sequences for the stall, LZC and mid-command reset cases.
module tb_gte_reg_writeback;
  import gte_pkg::*;

  typedef enum int {
    F_SXY0, F_SXY1, F_SXY2, F_SZ0, F_SZ1, F_SZ3, F_RGB0, F_RGB1, F_RGB2,
    F_MAC0, F_MAC1, F_MAC3, F_IR0, F_IR1, F_IR2, F_IR3, F_OTZ, F_FLAG,
    F_LZCS, F_LZCR
  } field_t;

  typedef struct {
    logic        instr;
    logic        wbValid;
    gteWbSel_t   sel;
    logic [31:0] wbData;
    logic [31:0] wbFlags;
    logic        cpuWr;
    logic [5:0]  addr;
    logic [31:0] cpuData;
    logic        expReady;
    field_t      fld;
    logic [31:0] expVal;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        instrStart;
  logic        cpuWr;
  logic [5:0]  cpuAddr;
  logic [31:0] cpuData;
  gteWbRegs_t  regs;

  int tests  = 0;
  int failed = 0;

  gte_reg_writeback_if wbIf ();

  gte_reg_writeback dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_instrStart (instrStart),
    .wb           (wbIf.slave),
    .i_cpuWr      (cpuWr),
    .i_cpuAddr    (cpuAddr),
    .i_cpuData    (cpuData),
    .o_regs       (regs)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] getField(input gteWbRegs_t r, input field_t f);
    case (f)
      F_SXY0: return r.sxy[0];
      F_SXY1: return r.sxy[1];
      F_SXY2: return r.sxy[2];
      F_SZ0:  return {16'h0, r.sz[0]};
      F_SZ1:  return {16'h0, r.sz[1]};
      F_SZ3:  return {16'h0, r.sz[3]};
      F_RGB0: return r.rgb[0];
      F_RGB1: return r.rgb[1];
      F_RGB2: return r.rgb[2];
      F_MAC0: return r.mac[0];
      F_MAC1: return r.mac[1];
      F_MAC3: return r.mac[3];
      F_IR0:  return {16'h0, r.ir[0]};
      F_IR1:  return {16'h0, r.ir[1]};
      F_IR2:  return {16'h0, r.ir[2]};
      F_IR3:  return {16'h0, r.ir[3]};
      F_OTZ:  return {16'h0, r.otz};
      F_FLAG: return r.flag;
      F_LZCS: return r.lzcs;
      F_LZCR: return {26'h0, r.lzcr};
      default: return 32'hDEAD_DEAD;
    endcase
  endfunction

  function automatic vec_t wbVec(input logic instr, input gteWbSel_t sel, input logic [31:0] d,
                                 input logic [31:0] fl, input field_t f, input logic [31:0] e);
    vec_t v;
    v = '{instr, 1'b1, sel, d, fl, 1'b0, 6'd0, 32'h0, 1'b1, f, e};
    return v;
  endfunction

  function automatic vec_t cpuVec(input logic [5:0] a, input logic [31:0] d,
                                  input field_t f, input logic [31:0] e);
    vec_t v;
    v = '{1'b0, 1'b0, WB_MAC0, 32'h0, 32'h0, 1'b1, a, d, 1'b0, f, e};
    return v;
  endfunction

  function automatic vec_t instrVec(input field_t f, input logic [31:0] e);
    vec_t v;
    v = '{1'b1, 1'b0, WB_MAC0, 32'h0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, f, e};
    return v;
  endfunction

  function automatic vec_t idleVec(input field_t f, input logic [31:0] e);
    vec_t v;
    v = '{1'b0, 1'b0, WB_MAC0, 32'h0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, f, e};
    return v;
  endfunction

  task automatic idleInputs();
    instrStart     = 1'b0;
    wbIf.wbValid   = 1'b0;
    wbIf.wbSel     = WB_MAC0;
    wbIf.wbData    = 32'h0;
    wbIf.wbFlags   = 32'h0;
    cpuWr          = 1'b0;
    cpuAddr        = 6'd0;
    cpuData        = 32'h0;
  endtask

  vec_t vecs[$];
  logic [31:0] lzcIn  [4];
  logic [31:0] lzcExp [4];

  initial begin
    rst = 1'b1;
    idleInputs();

    // Reset: ready low during reset, all state zero after it.
    @(negedge clk);
    #1 check("reset_ready", {31'h0, wbIf.wbReady}, 32'h0);
    @(posedge clk);
    #1 check("reset_all_zero", {31'h0, regs === '0}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // SXY FIFO pushes and CPU access.
    vecs.push_back(wbVec(1'b0, WB_SXY_PUSH, 32'h0001_0001, 32'h0, F_SXY2, 32'h0001_0001));
    vecs.push_back(wbVec(1'b0, WB_SXY_PUSH, 32'h0002_0002, 32'h0, F_SXY2, 32'h0002_0002));
    vecs.push_back(wbVec(1'b0, WB_SXY_PUSH, 32'h0003_0003, 32'h0, F_SXY0, 32'h0001_0001));
    vecs.push_back(idleVec(F_SXY1, 32'h0002_0002));
    vecs.push_back(idleVec(F_SXY2, 32'h0003_0003));
    vecs.push_back(wbVec(1'b0, WB_SXY_PUSH, 32'h0004_0004, 32'h0, F_SXY0, 32'h0002_0002));
    vecs.push_back(cpuVec(6'd15, 32'hAAAA_5555, F_SXY2, 32'hAAAA_5555));
    vecs.push_back(idleVec(F_SXY1, 32'h0004_0004));
    vecs.push_back(idleVec(F_SXY0, 32'h0003_0003));
    vecs.push_back(cpuVec(6'd13, 32'h0000_0001, F_SXY1, 32'h0000_0001));
    vecs.push_back(idleVec(F_SXY0, 32'h0003_0003));
    vecs.push_back(idleVec(F_SXY2, 32'hAAAA_5555));
    // FLAG accumulate / clear / summary bit.
    vecs.push_back(wbVec(1'b0, WB_MAC1, 32'h1111_1111, 32'h0100_0000, F_FLAG, 32'h8100_0000));
    vecs.push_back(idleVec(F_MAC1, 32'h1111_1111));
    vecs.push_back(instrVec(F_FLAG, 32'h0000_0000));
    // Clear then OR: only the new flag remains; bit 12 is outside the summary ranges.
    vecs.push_back(wbVec(1'b1, WB_MAC1, 32'h0000_0022, 32'h0000_1000, F_FLAG, 32'h0000_1000));
    vecs.push_back(wbVec(1'b0, WB_MAC3, 32'h0000_0033, 32'h0000_2000, F_FLAG, 32'h8000_3000));
    vecs.push_back(wbVec(1'b0, WB_IR3, 32'hABCD_1234, 32'hFFFF_FFFF, F_FLAG, 32'hFFFF_F000));
    vecs.push_back(idleVec(F_IR3, 32'h0000_1234));
    vecs.push_back(cpuVec(6'd63, 32'h0040_0FFF, F_FLAG, 32'h0040_0000));
    // Scalar and RGB targets.
    vecs.push_back(wbVec(1'b0, WB_OTZ, 32'hDEAD_BEEF, 32'h0, F_OTZ, 32'h0000_BEEF));
    vecs.push_back(wbVec(1'b0, WB_MAC0, 32'h8000_0001, 32'h0, F_MAC0, 32'h8000_0001));
    vecs.push_back(wbVec(1'b0, WB_IR0, 32'h0000_7FFF, 32'h0, F_IR0, 32'h0000_7FFF));
    vecs.push_back(wbVec(1'b0, WB_RGB_PUSH, 32'h0102_0304, 32'h0, F_RGB2, 32'h0102_0304));
    vecs.push_back(wbVec(1'b0, WB_RGB_PUSH, 32'h0506_0708, 32'h0, F_RGB1, 32'h0102_0304));
    vecs.push_back(cpuVec(6'd20, 32'hCAFE_0000, F_RGB0, 32'hCAFE_0000));
    // CPU map, including read-only and ignored addresses.
    vecs.push_back(cpuVec(6'd31, 32'h1234_5678, F_LZCR, 32'h0000_0000));
    vecs.push_back(cpuVec(6'd0, 32'hFFFF_FFFF, F_MAC0, 32'h8000_0001));
    vecs.push_back(cpuVec(6'd24, 32'h0000_0005, F_MAC0, 32'h0000_0005));
    vecs.push_back(cpuVec(6'd9, 32'h0001_8888, F_IR1, 32'h0000_8888));
    vecs.push_back(cpuVec(6'd7, 32'h0000_4444, F_OTZ, 32'h0000_4444));
    vecs.push_back(cpuVec(6'd16, 32'h0000_1111, F_SZ0, 32'h0000_1111));
    vecs.push_back(cpuVec(6'd27, 32'h0000_0077, F_MAC3, 32'h0000_0077));
    vecs.push_back(cpuVec(6'd30, 32'h0001_0000, F_LZCS, 32'h0001_0000));

    foreach (vecs[i]) begin
      @(negedge clk);
      instrStart   = vecs[i].instr;
      wbIf.wbValid = vecs[i].wbValid;
      wbIf.wbSel   = vecs[i].sel;
      wbIf.wbData  = vecs[i].wbData;
      wbIf.wbFlags = vecs[i].wbFlags;
      cpuWr        = vecs[i].cpuWr;
      cpuAddr      = vecs[i].addr;
      cpuData      = vecs[i].cpuData;
      #1 check($sformatf("vec%0d_ready", i), {31'h0, wbIf.wbReady}, {31'h0, vecs[i].expReady});
      @(posedge clk);
      #1 check($sformatf("vec%0d_field", i), getField(regs, vecs[i].fld), vecs[i].expVal);
    end
    @(negedge clk);
    idleInputs();

    // Stall: CPU write to IR0 blocks the IR2 command, which lands a cycle later.
    @(negedge clk);
    wbIf.wbValid = 1'b1;
    wbIf.wbSel   = WB_IR2;
    wbIf.wbData  = 32'h0000_1234;
    cpuWr        = 1'b1;
    cpuAddr      = 6'd8;
    cpuData      = 32'h0000_5678;
    #1 check("stall_ready", {31'h0, wbIf.wbReady}, 32'h0);
    @(posedge clk);
    #1 check("stall_ir0", getField(regs, F_IR0), 32'h0000_5678);
    check("stall_ir2_held", getField(regs, F_IR2), 32'h0000_0000);
    @(negedge clk);
    cpuWr = 1'b0;
    #1 check("retry_ready", {31'h0, wbIf.wbReady}, 32'h1);
    @(posedge clk);
    #1 check("retry_ir2", getField(regs, F_IR2), 32'h0000_1234);
    @(negedge clk);
    idleInputs();

    // LZCS / LZCR.
    lzcIn = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0001_0000, 32'h8000_0000};
`ifdef GTE_WB_LZC_EN
    lzcExp = '{32'd32, 32'd32, 32'd15, 32'd1};
`else
    lzcExp = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpuWr   = 1'b1;
      cpuAddr = CPU_LZCS;
      cpuData = lzcIn[i];
      @(posedge clk);
      #1 check($sformatf("lzcs%0d", i), getField(regs, F_LZCS), lzcIn[i]);
      check($sformatf("lzcr%0d", i), getField(regs, F_LZCR), lzcExp[i]);
    end
    @(negedge clk);
    idleInputs();

    // Four SZ pushes, then reset in the middle of a valid command.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      wbIf.wbValid = 1'b1;
      wbIf.wbSel   = WB_SZ_PUSH;
      wbIf.wbData  = 32'(i);
      @(posedge clk);
    end
    #1 check("sz_push_sz0", getField(regs, F_SZ0), 32'h1);
    check("sz_push_sz1", getField(regs, F_SZ1), 32'h2);
    check("sz_push_sz3", getField(regs, F_SZ3), 32'h4);
    @(negedge clk);
    wbIf.wbSel  = WB_MAC0;
    wbIf.wbData = 32'h9999_9999;
    rst         = 1'b1;
    #1 check("midrst_ready", {31'h0, wbIf.wbReady}, 32'h0);
    @(posedge clk);
    #1 check("midrst_all_zero", {31'h0, regs === '0}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    idleInputs();
    #1 check("postrst_ready", {31'h0, wbIf.wbReady}, 32'h1);
    @(posedge clk);
    #1 check("postrst_mac0", getField(regs, F_MAC0), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
